// File: rtl/counter8_bus_ctrl_if.sv
// Requester and counter-side signal bundle for counter8_bus_ctrl.
// The slave modport is the controller; the master modport is the requester/counter side.
interface counter8_bus_ctrl_if #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   op;
  logic [NREQ*8-1:0] wdata;
  logic              count_en;
  logic [NREQ-1:0]   gnt;
  logic [IDXW-1:0]   gnt_idx;
  logic              ack;
  logic [7:0]        rdata;
  logic              busy;
  logic              cnt_load;
  logic [7:0]        cnt_load_val;
  logic              cnt_en;
  logic              cnt_oe;
  logic [7:0]        cnt_q;

  modport slave (
    input  req, op, wdata, count_en, cnt_q,
    output gnt, gnt_idx, ack, rdata, busy, cnt_load, cnt_load_val, cnt_en, cnt_oe
  );

  modport master (
    output req, op, wdata, count_en, cnt_q,
    input  gnt, gnt_idx, ack, rdata, busy, cnt_load, cnt_load_val, cnt_en, cnt_oe
  );
endinterface

// File: rtl/counter8_bus_ctrl.sv
// Round-robin controller sharing one loadable tri-state 8-bit counter among NREQ requesters.
// Optional macro COUNTER_FREEZE_ON_READ_EN freezes the count during DRIVE/SAMPLE of a read.
module counter8_bus_ctrl #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic               clk,
  input  logic               arst,
  counter8_bus_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LOAD,
    S_DRIVE,
    S_SAMPLE,
    S_ACK
  } state_t;

  state_t          state, state_nxt;
  logic            win_vld;
  logic [IDXW-1:0] win_idx;
  logic [IDXW-1:0] cand;
  logic            op_l;
  logic [7:0]      wdata_l;

  logic [NREQ-1:0] gnt_nxt;
  logic [IDXW-1:0] gnt_idx_nxt;
  logic            ack_nxt;
  logic            busy_nxt;
  logic            load_nxt;
  logic [7:0]      load_val_nxt;
  logic            oe_nxt;

  // Scan downward so the last hit is the first requester above the last grantee.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDXW'((int'(bus.gnt_idx) + k) % NREQ);
      if (bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = bus.gnt;
    gnt_idx_nxt = bus.gnt_idx;
    unique case (state)
      S_IDLE: begin
        if (win_vld) begin
          state_nxt         = S_GRANT;
          gnt_nxt           = '0;
          gnt_nxt[win_idx]  = 1'b1;
          gnt_idx_nxt       = win_idx;
        end
      end
      S_GRANT:  state_nxt = op_l ? S_LOAD : S_DRIVE;
      S_LOAD:   state_nxt = S_ACK;
      S_DRIVE:  state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = S_ACK;
      S_ACK: begin
        state_nxt = S_IDLE;
        gnt_nxt   = '0;
      end
      default:  state_nxt = S_IDLE;
    endcase
    // Outputs are decoded from the next state so the registered pins line up with the state.
    ack_nxt      = (state_nxt == S_ACK);
    busy_nxt     = (state_nxt != S_IDLE);
    load_nxt     = (state_nxt == S_LOAD);
    load_val_nxt = (state_nxt == S_LOAD) ? wdata_l : 8'h00;
    oe_nxt       = (state_nxt == S_DRIVE) || (state_nxt == S_SAMPLE);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state            <= S_IDLE;
      bus.gnt          <= '0;
      bus.gnt_idx      <= IDXW'(NREQ - 1);
      bus.ack          <= 1'b0;
      bus.busy         <= 1'b0;
      bus.cnt_load     <= 1'b0;
      bus.cnt_load_val <= 8'h00;
      bus.cnt_oe       <= 1'b0;
      bus.rdata        <= 8'h00;
      op_l             <= 1'b0;
    end else begin
      state            <= state_nxt;
      bus.gnt          <= gnt_nxt;
      bus.gnt_idx      <= gnt_idx_nxt;
      bus.ack          <= ack_nxt;
      bus.busy         <= busy_nxt;
      bus.cnt_load     <= load_nxt;
      bus.cnt_load_val <= load_val_nxt;
      bus.cnt_oe       <= oe_nxt;
      if (state == S_IDLE && win_vld) op_l <= bus.op[win_idx];
      if (state == S_SAMPLE) bus.rdata <= bus.cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && win_vld) wdata_l <= bus.wdata[8*int'(win_idx) +: 8];
  end

`ifdef COUNTER_FREEZE_ON_READ_EN
  assign bus.cnt_en = !arst && bus.count_en && !((state == S_DRIVE) || (state == S_SAMPLE));
`else
  assign bus.cnt_en = !arst && bus.count_en;
`endif

endmodule

// File: tb/tb_counter8_bus_ctrl.sv
// Bench for counter8_bus_ctrl with a behavioural model of the shared counter.
module tb_counter8_bus_ctrl;
  localparam int NREQ = 4;
  localparam int IDXW = 2;

  typedef struct {
    int         idx;
    bit         rd;
    logic [7:0] val;
  } exp_t;

  logic clk;
  logic arst;
  logic [7:0] ctr_q;
  exp_t sb[$];
  int n_pass;
  int n_total;

  counter8_bus_ctrl_if #(.NREQ(NREQ), .IDXW(IDXW)) bus ();

  counter8_bus_ctrl #(.NREQ(NREQ), .IDXW(IDXW)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter model: load has priority over enable; undriven bus reads as junk.
  always @(posedge clk or posedge arst) begin
    if (arst) ctr_q <= 8'h00;
    else if (bus.cnt_load) ctr_q <= bus.cnt_load_val;
    else if (bus.cnt_en) ctr_q <= ctr_q + 8'h01;
  end
  assign bus.cnt_q = bus.cnt_oe ? ctr_q : 8'hEE;

  always @(negedge clk) begin
    if (!arst) begin
      if (bus.busy) begin
        n_total++;
        if (!$onehot(bus.gnt) || bus.gnt[bus.gnt_idx] !== 1'b1) begin
          $display("FAIL gnt_onehot: gnt=%b gnt_idx=%0d required one-hot matching idx", bus.gnt, bus.gnt_idx);
        end else n_pass++;
      end
      n_total++;
      if ((bus.cnt_load && bus.cnt_oe) || ((bus.cnt_load || bus.cnt_oe) && !bus.busy)) begin
        $display("FAIL pin_excl: load=%b oe=%b busy=%b required exclusive and busy", bus.cnt_load, bus.cnt_oe, bus.busy);
      end else n_pass++;
      if (bus.ack === 1'b1) begin
        exp_t e;
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected_ack: gnt_idx=%0d required no ack", bus.gnt_idx);
        end else begin
          e = sb.pop_front();
          if (bus.gnt_idx !== IDXW'(e.idx)) begin
            $display("FAIL sb_idx: got %0d required %0d", bus.gnt_idx, e.idx);
          end else if (e.rd && bus.rdata !== e.val) begin
            $display("FAIL sb_rdata: got %h required %h", bus.rdata, e.val);
          end else if (!e.rd && ctr_q !== e.val) begin
            $display("FAIL sb_loaded: counter %h required %h", ctr_q, e.val);
          end else n_pass++;
        end
      end
    end
  end

  task automatic wait_ack(output int n, output int nload, output int nload_at,
                          output int noe, output logic [7:0] lv);
    n = 0; nload = 0; nload_at = -1; noe = 0; lv = 8'h00;
    do begin
      @(posedge clk); #1;
      n++;
      if (bus.cnt_load) begin
        nload++;
        nload_at = n;
        lv = bus.cnt_load_val;
      end
      if (bus.cnt_oe) noe++;
    end while (bus.ack !== 1'b1 && n < 30);
  endtask

  task automatic start_req(input int idx, input bit is_load, input logic [7:0] wd);
    @(posedge clk); #1;
    bus.op[idx] = is_load;
    bus.wdata[8*idx +: 8] = wd;
    bus.req[idx] = 1'b1;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    bus.req = '0; bus.op = '0; bus.wdata = '0; bus.count_en = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if (bus.gnt !== 4'b0000 || bus.gnt_idx !== 2'd3 || bus.ack !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL reset_ctrl: gnt=%b idx=%0d ack=%b busy=%b required 0000/3/0/0", bus.gnt, bus.gnt_idx, bus.ack, bus.busy);
    end else n_pass++;
    n_total++;
    if (bus.rdata !== 8'h00 || bus.cnt_load !== 1'b0 || bus.cnt_load_val !== 8'h00 || bus.cnt_oe !== 1'b0) begin
      $display("FAIL reset_data: rdata=%h load=%b lv=%h oe=%b required 00/0/00/0", bus.rdata, bus.cnt_load, bus.cnt_load_val, bus.cnt_oe);
    end else n_pass++;
    n_total++;
    if (bus.cnt_en !== 1'b0) $display("FAIL reset_cnt_en: got %b required 0", bus.cnt_en);
    else n_pass++;
    bus.count_en = 1'b0;
    arst = 1'b0;
    @(negedge clk);
    bus.count_en = 1'b1;
    #1;
    n_total++;
    if (bus.cnt_en !== 1'b1) $display("FAIL cnt_en_pass: got %b required 1", bus.cnt_en);
    else n_pass++;
    bus.count_en = 1'b0;
  endtask

  task automatic test_load();
    int n, nl, nla, noe;
    logic [7:0] lv;
    start_req(0, 1'b1, 8'h5A);
    sb.push_back('{idx: 0, rd: 1'b0, val: 8'h5A});
    wait_ack(n, nl, nla, noe, lv);
    bus.req[0] = 1'b0;
    n_total++;
    if (n !== 3) $display("FAIL load_latency: got %0d required 3", n);
    else n_pass++;
    n_total++;
    if (nl !== 1 || nla !== 2 || lv !== 8'h5A || noe !== 0) begin
      $display("FAIL load_pulse: count=%0d at=%0d val=%h oe=%0d required 1/2/5a/0", nl, nla, lv, noe);
    end else n_pass++;
  endtask

  task automatic test_read();
    int n, nl, nla, noe;
    logic [7:0] lv;
    start_req(2, 1'b0, 8'h00);
    sb.push_back('{idx: 2, rd: 1'b1, val: 8'h5A});
    wait_ack(n, nl, nla, noe, lv);
    bus.req[2] = 1'b0;
    n_total++;
    if (n !== 4) $display("FAIL read_latency: got %0d required 4", n);
    else n_pass++;
    n_total++;
    if (noe !== 2 || nl !== 0) $display("FAIL read_oe: oe cycles=%0d loads=%0d required 2/0", noe, nl);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int n, nl, nla, noe;
    logic [7:0] lv;
    start_req(1, 1'b1, 8'hFF);
    sb.push_back('{idx: 1, rd: 1'b0, val: 8'hFF});
    wait_ack(n, nl, nla, noe, lv);
    bus.req[1] = 1'b0;
    start_req(1, 1'b0, 8'h00);
`ifdef COUNTER_FREEZE_ON_READ_EN
    sb.push_back('{idx: 1, rd: 1'b1, val: 8'h00});
`else
    sb.push_back('{idx: 1, rd: 1'b1, val: 8'h01});
`endif
    @(posedge clk); #1;
    bus.count_en = 1'b1;
    wait_ack(n, nl, nla, noe, lv);
    bus.count_en = 1'b0;
    bus.req[1] = 1'b0;
    n_total++;
    if (n + 1 !== 4) $display("FAIL wrap_latency: got %0d required 4", n + 1);
    else n_pass++;
  endtask

  task automatic test_req_drop();
    int n, nl, nla, noe;
    logic [7:0] lv;
    start_req(3, 1'b1, 8'h3C);
    sb.push_back('{idx: 3, rd: 1'b0, val: 8'h3C});
    wait_ack(n, nl, nla, noe, lv);
    bus.req[3] = 1'b0;
    start_req(3, 1'b0, 8'h00);
    sb.push_back('{idx: 3, rd: 1'b1, val: 8'h3C});
    @(posedge clk); #1;
    bus.req[3] = 1'b0;
    wait_ack(n, nl, nla, noe, lv);
    n_total++;
    if (n + 1 !== 4 || bus.ack !== 1'b1) $display("FAIL drop_latency: got %0d ack=%b required 4/1", n + 1, bus.ack);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n, nl, nla, noe;
    logic [7:0] lv;
    start_req(1, 1'b0, 8'h00);
    repeat (3) begin
      @(posedge clk); #1;
    end
    n_total++;
    if (bus.cnt_oe !== 1'b1) $display("FAIL mid_in_sample: oe=%b required 1", bus.cnt_oe);
    else n_pass++;
    #2 arst = 1'b1;
    #1;
    n_total++;
    if (bus.cnt_oe !== 1'b0 || bus.gnt !== 4'b0000 || bus.ack !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL mid_async: oe=%b gnt=%b ack=%b busy=%b required 0/0000/0/0", bus.cnt_oe, bus.gnt, bus.ack, bus.busy);
    end else n_pass++;
    bus.req = '0;
    @(negedge clk);
    arst = 1'b0;
    #1;
    n_total++;
    if (bus.gnt_idx !== 2'd3 || bus.rdata !== 8'h00) $display("FAIL mid_idx: idx=%0d rdata=%h required 3/00", bus.gnt_idx, bus.rdata);
    else n_pass++;
    @(posedge clk); #1;
    bus.op = 4'b1001;
    bus.wdata[7:0] = 8'h77;
    bus.wdata[31:24] = 8'h99;
    bus.req = 4'b1001;
    sb.push_back('{idx: 0, rd: 1'b0, val: 8'h77});
    sb.push_back('{idx: 3, rd: 1'b0, val: 8'h99});
    wait_ack(n, nl, nla, noe, lv);
    n_total++;
    if (bus.gnt_idx !== 2'd0) $display("FAIL mid_first_grant: got %0d required 0", bus.gnt_idx);
    else n_pass++;
    bus.req[0] = 1'b0;
    wait_ack(n, nl, nla, noe, lv);
    bus.req[3] = 1'b0;
  endtask

  task automatic test_round_robin();
    int n, nl, nla, noe;
    logic [7:0] lv;
    int order [5] = '{0, 1, 2, 3, 0};
    @(posedge clk); #1;
    bus.op = 4'b1111;
    bus.wdata = 32'h44332211;
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) sb.push_back('{idx: i, rd: 1'b0, val: 8'(8'h11 * (i + 1))});
    for (int i = 0; i < 5; i++) begin
      wait_ack(n, nl, nla, noe, lv);
      n_total++;
      if (bus.ack !== 1'b1 || bus.gnt_idx !== IDXW'(order[i]) || bus.gnt !== 4'(1 << order[i])) begin
        $display("FAIL rr_order[%0d]: ack=%b idx=%0d gnt=%b required idx %0d", i, bus.ack, bus.gnt_idx, bus.gnt, order[i]);
      end else n_pass++;
      bus.req[order[i]] = 1'b0;
      if (i == 0) begin
        @(posedge clk); #1;
        bus.wdata[7:0] = 8'h55;
        bus.req[0] = 1'b1;
        sb.push_back('{idx: 0, rd: 1'b0, val: 8'h55});
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_load();
    test_read();
    test_wrap();
    test_req_drop();
    test_reset_mid();
    test_round_robin();
    repeat (4) @(posedge clk);
    #1;
    n_total++;
    if (sb.size() != 0) $display("FAIL sb_leftover: %0d entries pending required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
